bram_port_arbiter: RTL and testbench

Shares one port of the softmax row BRAM (1028-bit rows, 256 deep) between two requesters: the UART host loader (requester 0) and the softmax core (requester 1). Arbitration is round-robin with an optional lock for multi-row bursts. Read data returns with a fixed latency, tagged back to the issuing requester. The block sits between the UART/BRAM controller, the core, and the BRAM, and it also counts contention cycles for debug.

---
 rtl/bram_port_arbiter_pkg.sv | 17 +
 rtl/bram_port_arbiter_rd_tag_pipe.sv | 30 +++
 rtl/bram_port_arbiter.sv | 121 ++++++++++++
 tb/tb_bram_port_arbiter.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/bram_port_arbiter_pkg.sv
// Shared constants and types for the softmax row BRAM port arbiter.
// Row/address widths are shared with uart_bram_controller and the softmax core.
package bram_port_arbiter_pkg;

    localparam int ROW_W      = 1028;
    localparam int ROW_ADDR_W = 8;

    localparam logic REQ_HOST = 1'b0;
    localparam logic REQ_CORE = 1'b1;

    typedef enum logic [1:0] {
        S_FREE  = 2'd0,
        S_LOCK0 = 2'd1,
        S_LOCK1 = 2'd2
    } arb_state_t;

endpackage

// File: rtl/bram_port_arbiter_rd_tag_pipe.sv
// Delay line carrying {valid, owner} for each issued read until its BRAM data returns.
// One stage covers command registration, RD_LAT stages cover the BRAM read latency.
module rd_tag_pipe #(
    parameter int RD_LAT = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic vld,
    input  logic owner,
    output logic vld_out,
    output logic owner_out
);

    logic [RD_LAT:0] vld_p;
    logic [RD_LAT:0] own_p;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p <= '0;
            own_p <= '0;
        end else begin
            vld_p <= {vld_p[RD_LAT-1:0], vld};
            own_p <= {own_p[RD_LAT-1:0], owner};
        end
    end

    assign vld_out   = vld_p[RD_LAT];
    assign owner_out = own_p[RD_LAT];

endmodule

// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter with optional burst lock sharing one softmax row BRAM port
// between the UART host loader (requester 0) and the softmax core (requester 1).
module bram_port_arbiter
    import bram_port_arbiter_pkg::*;
#(
    parameter int DATA_W = ROW_W,
    parameter int ADDR_W = ROW_ADDR_W,
    parameter int RD_LAT = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req0,
    input  logic              i_req1,
    input  logic              i_we0,
    input  logic              i_we1,
    input  logic [ADDR_W-1:0] i_addr0,
    input  logic [ADDR_W-1:0] i_addr1,
    input  logic [DATA_W-1:0] i_din0,
    input  logic [DATA_W-1:0] i_din1,
    input  logic              i_lock0,
    input  logic              i_lock1,
    output logic              o_gnt0,
    output logic              o_gnt1,
    output logic              o_rvalid0,
    output logic              o_rvalid1,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_mem_cen,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_din,
    input  logic [DATA_W-1:0] i_mem_dout,
    output logic [15:0]       o_conflict_cnt,
    output logic [1:0]        o_owner
);

    function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
        return (en && (v != 16'hFFFF)) ? v + 16'd1 : v;
    endfunction

    arb_state_t state;
    logic       last;
    logic       gnt0, gnt1;
    logic       acc, win, we_sel, lock_sel, stall;
    logic       tag_vld, tag_own;

    // In S_FREE a tie goes to whichever requester was not served last.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        case (state)
            S_FREE: begin
                if (i_req0 && i_req1) begin
                    gnt0 = (last == REQ_CORE);
                    gnt1 = (last == REQ_HOST);
                end else begin
                    gnt0 = i_req0;
                    gnt1 = i_req1;
                end
            end
            S_LOCK0: gnt0 = i_req0;
            S_LOCK1: gnt1 = i_req1;
            default: ;
        endcase
    end

    assign acc      = gnt0 | gnt1;
    assign win      = gnt1;
    assign we_sel   = gnt1 ? i_we1   : i_we0;
    assign lock_sel = gnt1 ? i_lock1 : i_lock0;
    assign stall    = (i_req0 & ~gnt0) | (i_req1 & ~gnt1);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state          <= S_FREE;
            last           <= REQ_CORE;
            o_conflict_cnt <= '0;
        end else begin
            o_conflict_cnt <= sat_inc(o_conflict_cnt, stall);
            if (acc) begin
                last  <= win;
                state <= lock_sel ? (win ? S_LOCK1 : S_LOCK0) : S_FREE;
            end else if ((state == S_LOCK0 && !i_lock0) || (state == S_LOCK1 && !i_lock1)) begin
                state <= S_FREE;
            end
        end
    end

    // Command stage: accepted access becomes visible on the BRAM port next cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_mem_cen  <= 1'b0;
            o_mem_we   <= 1'b0;
            o_mem_addr <= '0;
            o_mem_din  <= '0;
        end else begin
            o_mem_cen <= acc;
            o_mem_we  <= acc & we_sel;
            if (acc) begin
                o_mem_addr <= gnt1 ? i_addr1 : i_addr0;
                o_mem_din  <= gnt1 ? i_din1  : i_din0;
            end
        end
    end

    rd_tag_pipe #(.RD_LAT(RD_LAT)) u_tag (
        .clk      (i_clk),
        .rst_n    (i_rst_n),
        .vld      (acc & ~we_sel),
        .owner    (win),
        .vld_out  (tag_vld),
        .owner_out(tag_own)
    );

    assign o_gnt0    = gnt0;
    assign o_gnt1    = gnt1;
    assign o_rvalid0 = tag_vld & ~tag_own;
    assign o_rvalid1 = tag_vld &  tag_own;
    assign o_rdata   = i_mem_dout;
    assign o_owner   = state;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter with a two-cycle-latency BRAM model.
module tb_bram_port_arbiter;

    localparam int DW = 1028;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req0, req1, we0, we1, lock0, lock1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] din0, din1;
    logic          gnt0, gnt1, rvalid0, rvalid1;
    logic [DW-1:0] rdata;
    logic          mem_cen, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din, mem_dout;
    logic [15:0]   conflict_cnt;
    logic [1:0]    owner;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    bram_port_arbiter dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req0(req0), .i_req1(req1), .i_we0(we0), .i_we1(we1),
        .i_addr0(addr0), .i_addr1(addr1), .i_din0(din0), .i_din1(din1),
        .i_lock0(lock0), .i_lock1(lock1),
        .o_gnt0(gnt0), .o_gnt1(gnt1), .o_rvalid0(rvalid0), .o_rvalid1(rvalid1),
        .o_rdata(rdata), .o_mem_cen(mem_cen), .o_mem_we(mem_we),
        .o_mem_addr(mem_addr), .o_mem_din(mem_din), .i_mem_dout(mem_dout),
        .o_conflict_cnt(conflict_cnt), .o_owner(owner)
    );

    function automatic logic [DW-1:0] row_pat(input logic [7:0] a);
        return {a[3:0], {128{a}}};
    endfunction

    // BRAM model: read data appears two cycles after the command is on the port.
    logic [DW-1:0] mem [256];
    logic [DW-1:0] rd_stage;
    bit            mem_init;
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= row_pat(i[7:0]);
            mem_init <= 1'b1;
        end else if (mem_cen && mem_we) begin
            mem[mem_addr] <= mem_din;
        end else if (mem_cen) begin
            rd_stage <= mem[mem_addr];
        end
        mem_dout <= rd_stage;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_row(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s observed_lo=%0h expected_lo=%0h", tag, got[63:0], exp[63:0]);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
        addr0 = '0; addr1 = '0; din0 = '0; din1 = '0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    logic [DW-1:0] wdata;

    initial begin
        wdata = {4'h0, {128{8'hA5}}};

        // ---- reset state ----
        do_reset();
        #1;
        chk("rst_cen", mem_cen, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_rvalid0", rvalid0, 0);
        chk("rst_rvalid1", rvalid1, 0);
        chk("rst_cnt", conflict_cnt, 0);
        chk("rst_owner", owner, 0);
        chk("rst_gnt0", gnt0, 0);
        cyc();

        // ---- single read of row 5 ----
        req0 = 1; addr0 = 8'h05;
        #1 chk("sr_gnt0", gnt0, 1); chk("sr_gnt1", gnt1, 0);
        cyc(); req0 = 0;
        #1 chk("sr_cen", mem_cen, 1); chk("sr_addr", mem_addr, 5); chk("sr_we", mem_we, 0);
        cyc();
        #1 chk("sr_cen_idle", mem_cen, 0); chk("sr_early_rvalid", rvalid0, 0);
        cyc();
        #1 chk("sr_rvalid0", rvalid0, 1); chk("sr_rvalid1", rvalid1, 0);
        chk_row("sr_rdata", rdata, row_pat(8'h05));
        cyc();
        #1 chk("sr_rvalid0_off", rvalid0, 0);

        // ---- tie after reset: requester 0 first ----
        do_reset();
        req0 = 1; addr0 = 8'h01; req1 = 1; addr1 = 8'h02;
        #1 chk("tie_gnt0", gnt0, 1); chk("tie_gnt1", gnt1, 0);
        cyc(); req0 = 0;
        #1 chk("tie2_gnt1", gnt1, 1); chk("tie2_gnt0", gnt0, 0); chk("tie_cnt", conflict_cnt, 1);
        cyc(); req1 = 0;
        #1 chk("tie_cnt_hold", conflict_cnt, 1);

        // ---- alternation with in-order read tags ----
        do_reset();
        addr0 = 8'h10; addr1 = 8'h20;
        for (int i = 0; i < 9; i++) begin
            req0 = (i < 6); req1 = (i < 6);
            #1;
            if (i < 6) begin
                chk($sformatf("alt_gnt0_%0d", i), gnt0, (i % 2 == 0));
                chk($sformatf("alt_gnt1_%0d", i), gnt1, (i % 2 == 1));
            end
            if (i >= 3) begin
                chk($sformatf("alt_rv0_%0d", i), rvalid0, ((i - 3) % 2 == 0));
                chk($sformatf("alt_rv1_%0d", i), rvalid1, ((i - 3) % 2 == 1));
                chk_row($sformatf("alt_rdata_%0d", i), rdata,
                        ((i - 3) % 2 == 0) ? row_pat(8'h10) : row_pat(8'h20));
            end
            cyc();
        end
        chk("alt_cnt", conflict_cnt, 6);

        // ---- lock burst by requester 1 while requester 0 waits ----
        do_reset();
        req0 = 1; addr0 = 8'h07;
        #1 chk("lk_pre_gnt0", gnt0, 1);
        cyc();
        req0 = 1; addr0 = 8'h31; req1 = 1; addr1 = 8'h30;
        for (int k = 0; k < 4; k++) begin
            lock1 = (k < 3);
            #1;
            chk($sformatf("lk_gnt1_%0d", k), gnt1, 1);
            chk($sformatf("lk_gnt0_%0d", k), gnt0, 0);
            if (k > 0) chk($sformatf("lk_owner_%0d", k), owner, 2);
            cyc();
        end
        req1 = 0; lock1 = 0;
        #1 chk("lk_gnt0", gnt0, 1); chk("lk_gnt1_off", gnt1, 0);
        chk("lk_owner_free", owner, 0); chk("lk_cnt", conflict_cnt, 4);
        cyc(); req0 = 0;
        #1 chk("lk_cnt_hold", conflict_cnt, 4);

        // ---- write A5 to row 3, then read it back ----
        do_reset();
        req0 = 1; we0 = 1; addr0 = 8'h03; din0 = wdata;
        #1 chk("wr_gnt0", gnt0, 1);
        cyc(); we0 = 0;
        #1 chk("rd_gnt0", gnt0, 1); chk("wr_cen", mem_cen, 1); chk("wr_we", mem_we, 1);
        chk("wr_addr", mem_addr, 3); chk_row("wr_din", mem_din, wdata);
        cyc(); req0 = 0;
        #1 chk("rd_cen", mem_cen, 1); chk("rd_we", mem_we, 0);
        cyc();
        #1 chk("wr_no_rvalid", rvalid0, 0); chk("idle_we", mem_we, 0);
        cyc();
        #1 chk("wr_rd_rvalid0", rvalid0, 1); chk_row("wr_rd_rdata", rdata, wdata);

        // ---- reset asserted while a read is in flight ----
        do_reset();
        req0 = 1; addr0 = 8'h05; req1 = 1; addr1 = 8'h09;
        #1 chk("mr_gnt0", gnt0, 1);
        cyc(); req0 = 0; req1 = 0;
        #1 chk("mr_cen", mem_cen, 1); chk("mr_cnt_pre", conflict_cnt, 1);
        rst_n = 0;
        #1 chk("mr_cen_rst", mem_cen, 0); chk("mr_addr_rst", mem_addr, 0);
        chk_row("mr_din_rst", mem_din, '0); chk("mr_cnt_rst", conflict_cnt, 0);
        chk("mr_owner_rst", owner, 0); chk("mr_gnt_rst", {gnt0, gnt1}, 0);
        cyc(); rst_n = 1;
        for (int j = 0; j < 4; j++) begin
            #1;
            chk($sformatf("mr_rv0_%0d", j), rvalid0, 0);
            chk($sformatf("mr_rv1_%0d", j), rvalid1, 0);
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
